// File: rtl/alu_seq_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the sequential ALU.
package alu_seq_pkg;

    typedef enum logic [4:0] {
        NOP         = 5'd0,
        MOV         = 5'd1,
        CMP         = 5'd2,
        TEST        = 5'd3,
        SHFT_L      = 5'd4,
        SHFT_R      = 5'd5,
        ADD         = 5'd6,
        ADC         = 5'd7,
        SUB         = 5'd8,
        SBB         = 5'd9,
        MUL         = 5'd10,
        AND         = 5'd11,
        OR          = 5'd12,
        XOR         = 5'd13,
        NOT         = 5'd14,
        CLEAR_FLAGS = 5'd15,
        DIV         = 5'd16
    } alu_op_t;

    localparam int FLAG_Z = 7;
    localparam int FLAG_S = 6;
    localparam int FLAG_C = 5;
    localparam int FLAG_O = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider; one bit per cycle.
// fin is asserted during the last iteration and lo/hi already carry the final values then.
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic                 is_div,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 fin,
    output logic [WORD_SIZE-1:0] lo,
    output logic [WORD_SIZE-1:0] hi
);

    localparam int CNT_W = $clog2(WORD_SIZE);

    logic                 active;
    logic [CNT_W-1:0]     cnt;
    logic                 is_div_r;
    logic [WORD_SIZE-1:0] acc;
    logic [WORD_SIZE-1:0] mq;
    logic [WORD_SIZE-1:0] dv;
    logic [WORD_SIZE-1:0] acc_nxt;
    logic [WORD_SIZE-1:0] mq_nxt;
    logic [WORD_SIZE:0]   mul_sum;
    logic [WORD_SIZE:0]   div_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (go) begin
            active <= 1'b1;
            cnt    <= CNT_W'(WORD_SIZE - 1);
        end else if (active) begin
            if (cnt == '0)
                active <= 1'b0;
            else
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (go) begin
            acc      <= '0;
            mq       <= a;
            dv       <= b;
            is_div_r <= is_div;
        end else if (active) begin
            acc <= acc_nxt;
            mq  <= mq_nxt;
        end
    end

    // Multiply: {acc,mq} shifts right with the multiplicand added on mq[0].
    // Divide: {acc,mq} shifts left and the divisor is subtracted whenever it fits;
    // a zero divisor always "fits", giving an all-ones quotient and remainder A.
    always_comb begin
        mul_sum = mq[0] ? ({1'b0, acc} + {1'b0, dv}) : {1'b0, acc};
        div_sh  = {acc, mq[WORD_SIZE-1]};
        if (is_div_r) begin
            if (div_sh >= {1'b0, dv}) begin
                acc_nxt = div_sh[WORD_SIZE-1:0] - dv;
                mq_nxt  = {mq[WORD_SIZE-2:0], 1'b1};
            end else begin
                acc_nxt = div_sh[WORD_SIZE-1:0];
                mq_nxt  = {mq[WORD_SIZE-2:0], 1'b0};
            end
        end else begin
            acc_nxt = mul_sum[WORD_SIZE:1];
            mq_nxt  = {mul_sum[0], mq[WORD_SIZE-1:1]};
        end
    end

    assign fin = active && (cnt == '0);
    assign lo  = mq_nxt;
    assign hi  = acc_nxt;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle datapath and flag logic, start/done FSM,
// and an iterative MUL/DIV engine with a persistent flags register.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4:0]           mode_select,
    input  logic [WORD_SIZE-1:0] input_A,
    input  logic [WORD_SIZE-1:0] input_B,
    output logic [WORD_SIZE-1:0] output_C,
    output logic [WORD_SIZE-1:0] output_hi,
    output logic [7:0]           flags,
    output logic                 busy,
    output logic                 done
);

    localparam logic [WORD_SIZE-1:0] W_VAL = WORD_SIZE'(WORD_SIZE);

    state_t               state;
    state_t               state_nxt;
    alu_op_t              op_in;
    alu_op_t              op_r;
    logic                 b_zero_r;
    logic                 accept;
    logic                 is_muldiv_in;
    logic                 go;
    logic                 fin;
    logic [WORD_SIZE-1:0] md_lo;
    logic [WORD_SIZE-1:0] md_hi;

    logic [WORD_SIZE:0]   cin;
    logic [WORD_SIZE:0]   add_w;
    logic [WORD_SIZE:0]   sub_w;
    logic [WORD_SIZE:0]   shl_w;
    logic [WORD_SIZE:0]   shr_w;
    logic                 add_ovf;
    logic                 sub_ovf;
    logic                 shr_c;
    logic [WORD_SIZE-1:0] res;
    logic                 c_n;
    logic                 o_n;
    logic                 wr_res;
    logic                 wr_zs;
    logic                 wr_co;
    logic                 clr;
    logic                 md_c;
    logic                 md_o;

    assign op_in        = alu_op_t'(mode_select);
    assign accept       = (state == IDLE) && start;
    assign is_muldiv_in = (op_in == MUL) || (op_in == DIV);
    assign go           = accept && is_muldiv_in;
    assign busy         = (state == RUN);

    alu_seq_muldiv #(.WORD_SIZE(WORD_SIZE)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (go),
        .is_div (op_in == DIV),
        .a      (input_A),
        .b      (input_B),
        .fin    (fin),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = RUN;
            RUN:     if (fin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (go) begin
            op_r     <= op_in;
            b_zero_r <= (input_B == '0);
        end
    end

    // Single-cycle datapath evaluated straight from the inputs at the accept edge.
    always_comb begin
        cin     = {{WORD_SIZE{1'b0}}, flags[FLAG_C]};
        add_w   = {1'b0, input_A} + {1'b0, input_B} + ((op_in == ADC) ? cin : '0);
        sub_w   = {1'b0, input_A} - {1'b0, input_B} - ((op_in == SBB) ? cin : '0);
        add_ovf = (input_A[WORD_SIZE-1] == input_B[WORD_SIZE-1]) &&
                  (add_w[WORD_SIZE-1] != input_A[WORD_SIZE-1]);
        sub_ovf = (input_A[WORD_SIZE-1] != input_B[WORD_SIZE-1]) &&
                  (sub_w[WORD_SIZE-1] != input_A[WORD_SIZE-1]);
        shl_w   = {1'b0, input_A} << input_B;
        shr_w   = {input_A, 1'b0} >> input_B;
        // At B == W the carry is defined as bit W-B (bit 0) for both directions.
        if (input_B < W_VAL)
            shr_c = shr_w[0];
        else if (input_B == W_VAL)
            shr_c = input_A[0];
        else
            shr_c = 1'b0;

        res    = '0;
        c_n    = 1'b0;
        o_n    = 1'b0;
        wr_res = 1'b0;
        wr_zs  = 1'b0;
        wr_co  = 1'b0;
        clr    = 1'b0;
        case (op_in)
            MOV:         begin res = input_B; wr_res = 1'b1; wr_zs = 1'b1; end
            CMP:         begin res = sub_w[WORD_SIZE-1:0]; c_n = sub_w[WORD_SIZE]; o_n = sub_ovf;
                               wr_zs = 1'b1; wr_co = 1'b1; end
            TEST:        begin res = input_A & input_B; wr_zs = 1'b1; wr_co = 1'b1; end
            SHFT_L:      begin res = shl_w[WORD_SIZE-1:0]; c_n = shl_w[WORD_SIZE];
                               wr_res = 1'b1; wr_zs = 1'b1; wr_co = 1'b1; end
            SHFT_R:      begin res = input_A >> input_B; c_n = shr_c;
                               wr_res = 1'b1; wr_zs = 1'b1; wr_co = 1'b1; end
            ADD, ADC:    begin res = add_w[WORD_SIZE-1:0]; c_n = add_w[WORD_SIZE]; o_n = add_ovf;
                               wr_res = 1'b1; wr_zs = 1'b1; wr_co = 1'b1; end
            SUB, SBB:    begin res = sub_w[WORD_SIZE-1:0]; c_n = sub_w[WORD_SIZE]; o_n = sub_ovf;
                               wr_res = 1'b1; wr_zs = 1'b1; wr_co = 1'b1; end
            AND:         begin res = input_A & input_B; wr_res = 1'b1; wr_zs = 1'b1; wr_co = 1'b1; end
            OR:          begin res = input_A | input_B; wr_res = 1'b1; wr_zs = 1'b1; wr_co = 1'b1; end
            XOR:         begin res = input_A ^ input_B; wr_res = 1'b1; wr_zs = 1'b1; wr_co = 1'b1; end
            NOT:         begin res = ~input_A; wr_res = 1'b1; wr_zs = 1'b1; wr_co = 1'b1; end
            CLEAR_FLAGS: clr = 1'b1;
            default:     ;
        endcase
    end

    always_comb begin
        md_c = 1'b0;
        md_o = b_zero_r;
        if (op_r == MUL) begin
            md_c = (md_hi != '0);
            md_o = (md_hi != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_C  <= '0;
            output_hi <= '0;
            flags     <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept && !is_muldiv_in) begin
                done <= 1'b1;
                if (clr)
                    flags <= '0;
                if (wr_res) begin
                    output_C  <= res;
                    output_hi <= '0;
                end
                if (wr_zs) begin
                    flags[FLAG_Z] <= (res == '0);
                    flags[FLAG_S] <= res[WORD_SIZE-1];
                end
                if (wr_co) begin
                    flags[FLAG_C] <= c_n;
                    flags[FLAG_O] <= o_n;
                end
            end else if ((state == RUN) && fin) begin
                done          <= 1'b1;
                output_C      <= md_lo;
                output_hi     <= md_hi;
                flags[FLAG_Z] <= (md_lo == '0);
                flags[FLAG_S] <= md_lo[WORD_SIZE-1];
                flags[FLAG_C] <= md_c;
                flags[FLAG_O] <= md_o;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WORD_SIZE=8: directed vectors push expectations,
// a negedge monitor pops one per done pulse and checks result, high word, flags and timing.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [4:0]   mode_select;
    logic [W-1:0] input_A;
    logic [W-1:0] input_B;
    logic [W-1:0] output_C;
    logic [W-1:0] output_hi;
    logic [7:0]   flags;
    logic         busy;
    logic         done;

    typedef struct {
        string      nm;
        logic [7:0] c;
        logic [7:0] hi;
        logic [7:0] f;
        int         due;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   ndone  = 0;

    alu_seq #(.WORD_SIZE(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode_select (mode_select),
        .input_A     (input_A),
        .input_B     (input_B),
        .output_C    (output_C),
        .output_hi   (output_hi),
        .flags       (flags),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic issue(input alu_op_t op, input logic [7:0] a, input logic [7:0] b,
                         input bit push, input logic [7:0] ec, input logic [7:0] eh,
                         input logic [7:0] ef, input string nm);
        exp_t e;
        mode_select = op;
        input_A     = a;
        input_B     = b;
        start       = 1'b1;
        if (push) begin
            e.nm  = nm;
            e.c   = ec;
            e.hi  = eh;
            e.f   = ef;
            e.due = cyc + 1 + (((op == MUL) || (op == DIV)) ? W : 0);
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles expected busy=0", n);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            ndone++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e = q.pop_front();
                chk({e.nm, "_C"},     output_C,  e.c);
                chk({e.nm, "_hi"},    output_hi, e.hi);
                chk({e.nm, "_flags"}, flags,     e.f);
                chk({e.nm, "_cycle"}, cyc,       e.due);
                chk({e.nm, "_busy"},  busy,      0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int nd0;
        rst_n       = 1'b0;
        start       = 1'b0;
        mode_select = '0;
        input_A     = '0;
        input_B     = '0;
        repeat (3) @(negedge clk);
        chk("rst_C", output_C, 0);
        chk("rst_hi", output_hi, 0);
        chk("rst_flags", flags, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(ADD, 8'd255, 8'd1,   1, 8'd0,   8'd0, 8'hA0, "add");
        issue(ADC, 8'd1,   8'd0,   1, 8'd2,   8'd0, 8'h00, "adc");
        issue(SUB, 8'd127, 8'hFF,  1, 8'd128, 8'd0, 8'h70, "sub");
        issue(SBB, 8'd3,   8'd1,   1, 8'd1,   8'd0, 8'h00, "sbb");

        issue(MUL, 8'd200, 8'd3,   1, 8'h58,  8'h02, 8'h30, "mul");
        wait_idle(n);
        chk("mul_busy_cycles", n, W);
        issue(DIV, 8'd100, 8'd7,   1, 8'd14,  8'd2,  8'h00, "div");
        wait_idle(n);
        chk("div_busy_cycles", n, W);
        issue(DIV, 8'd9,   8'd0,   1, 8'd255, 8'd9,  8'h50, "div0");
        wait_idle(n);
        issue(OR,  8'h0C,  8'h03,  1, 8'h0F,  8'd0,  8'h00, "or_hi_clear");

        // A start during RUN must be dropped, not queued
        issue(MUL, 8'd15,  8'd17,  1, 8'hFF,  8'd0,  8'h40, "mul_ign");
        @(negedge clk);
        mode_select = ADD;
        input_A     = 8'd1;
        input_B     = 8'd1;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        repeat (3) @(negedge clk);
        chk("ign_C_held", output_C, 8'hFF);

        // Reset in the middle of a MUL
        issue(MUL, 8'd200, 8'd3,   0, 8'd0,   8'd0,  8'h00, "mul_abort");
        nd0 = ndone;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_C", output_C, 0);
        chk("abort_hi", output_hi, 0);
        chk("abort_flags", flags, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done", ndone, nd0);

        issue(SHFT_L, 8'd2,   8'd6, 1, 8'd128, 8'd0, 8'h40, "shl6");
        issue(SHFT_L, 8'd128, 8'd1, 1, 8'd0,   8'd0, 8'hA0, "shl1");
        issue(CLEAR_FLAGS, 8'd5, 8'd5, 1, 8'd0, 8'd0, 8'h00, "clr0");
        issue(XOR,    8'hF0,  8'h0F, 1, 8'hFF, 8'd0, 8'h40, "xor");
        issue(CMP,    8'd5,   8'd5,  1, 8'hFF, 8'd0, 8'h80, "cmp");
        issue(CLEAR_FLAGS, 8'd0, 8'd0, 1, 8'hFF, 8'd0, 8'h00, "clr1");
        issue(TEST,   8'hAA,  8'h55, 1, 8'hFF, 8'd0, 8'h80, "test");
        issue(ADD,    8'd255, 8'd1,  1, 8'd0,  8'd0, 8'hA0, "add2");
        issue(MOV,    8'd0,   8'h80, 1, 8'h80, 8'd0, 8'h60, "mov");
        issue(SHFT_R, 8'h81,  8'd1,  1, 8'h40, 8'd0, 8'h20, "shr1");
        issue(SHFT_R, 8'h81,  8'd0,  1, 8'h81, 8'd0, 8'h40, "shr0");
        issue(SHFT_L, 8'h81,  8'd8,  1, 8'd0,  8'd0, 8'hA0, "shl8");
        issue(NOT,    8'h0F,  8'd0,  1, 8'hF0, 8'd0, 8'h40, "not");
        issue(NOP,    8'd1,   8'd2,  1, 8'hF0, 8'd0, 8'h40, "nop");

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential successor to the 8-bit combinational `alu`. It keeps the same opcode set and flag semantics and adds DIV. It holds ZERO/SIGN/CARRY/OVERFLOW in a persistent flags register, so ADC and SBB chain across operations. It uses a start/done handshake and multi-cycle shift-add MUL and restoring DIV with a double-width result. It sits between the register file and the writeback mux of the tau core.

## Interface
Parameters:
- `WORD_SIZE`, default 8: operand and result width; must be at least 4.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: request; sampled only while the FSM is IDLE.
- `mode_select`, input, 5: opcode, encoded per `alu_seq_pkg::alu_op_t`.
- `input_A`, input, `WORD_SIZE`: operand A; latched on accept.
- `input_B`, input, `WORD_SIZE`: operand B; latched on accept.
- `output_C`, output, `WORD_SIZE`: registered result, low word.
- `output_hi`, output, `WORD_SIZE`: registered MUL high word or DIV remainder; cleared by every other result-writing op.
- `flags`, output, 8: bit [7] ZERO, [6] SIGN, [5] CARRY, [4] OVERFLOW; bits [3:0] are always 0.
- `busy`, output, 1: high while the FSM is in RUN.
- `done`, output, 1: one-cycle pulse when the result and flags have been updated.

## Operation
- Opcodes: NOP=0, MOV, CMP, TEST, SHFT_L, SHFT_R, ADD, ADC, SUB, SBB, MUL, AND, OR, XOR, NOT, CLEAR_FLAGS=15, DIV=16. Codes 17–31 behave as NOP.
- Z = result==0; S = result[W-1]. Both are computed on the low word.
- NOP: nothing changes.
- CLEAR_FLAGS: flags become 0; results are unchanged.
- MOV: C = B; updates Z and S; CARRY and OVERFLOW are kept.
- ADD/ADC: C = A+B(+CARRY). CARRY is the unsigned carry-out. OVERFLOW is the signed overflow: operands have the same sign and the result sign differs.
- SUB/SBB: C = A−B(−CARRY). CARRY is the borrow: A < B(+CARRY) unsigned. OVERFLOW is the signed overflow: operand signs differ and the result sign differs from A.
- CMP: flags as SUB; results are unchanged.
- TEST: flags as AND; results are unchanged.
- AND/OR/XOR/NOT: logic result (NOT ignores B). CARRY=0, OVERFLOW=0.
- SHFT_L/SHFT_R: logical shift by the amount B.
  - CARRY = last bit shifted out; OVERFLOW = 0.
  - B=0: C = A and CARRY=0.
  - B ≥ W: C = 0, and CARRY = the bit at index W−B when that index is valid, else 0.
- MUL: unsigned, 2W-bit product. `output_C` = low word, `output_hi` = high word. CARRY = OVERFLOW = (high word ≠ 0).
- DIV: unsigned. `output_C` = quotient, `output_hi` = remainder; CARRY=0, OVERFLOW=0.
- Divide by zero: quotient = all ones, remainder = A, OVERFLOW=1, CARRY=0.
- FSM states:
  - IDLE: on `start`, latch operands and opcode. MUL/DIV go to RUN with counter = W−1. Every other opcode commits at that same edge and stays in IDLE.
  - RUN: one shift-add or shift-subtract iteration per cycle. At counter==0, commit results and flags, then return to IDLE.
- `start` during RUN is ignored; it is not queued.
- Reset (asynchronous, any state): `output_C`, `output_hi`, `flags`, `busy`, `done` and the counter all go to 0; state = IDLE. An in-flight MUL/DIV is discarded without a `done`.

## Timing
- Single-cycle ops: `start` is sampled at edge E. `output_C` and `flags` are valid after E. `done` is high for the cycle following E. `busy` stays 0.
- MUL/DIV:
  - `busy` is high from after E through the cycle before E+W.
  - Results, flags and `done` appear after edge E+W (latency W cycles); `busy` falls at that same edge.
- Back-to-back: a new `start` is accepted in the same cycle that `done` is high.
- ADC/SBB read the CARRY value registered before their accept edge.
- Outputs hold between operations.

## Structure
- `alu_seq_pkg`:
  - `alu_op_t` enum (5-bit, values above);
  - flag bit index constants `FLAG_Z`=7, `FLAG_S`=6, `FLAG_C`=5, `FLAG_O`=4;
  - FSM state enum `{IDLE, RUN}`.
- Sub-module `alu_seq_muldiv`: iterative shift-add multiplier and restoring divider sharing one W-bit accumulator and a counter, with `go`/`fin` handshake. The top level contains the single-cycle datapath, flag logic and FSM.

## Test plan
All values below are for W=8.
- ADD 255+1 → C=0, flags Z=1 C=1 S=0 O=0. Then ADC 1+0 → C=2, `done` one cycle after `start`.
- SUB 127−(−1) → C=128, S=1 C=1 O=1. Then SBB 3−1 → C=1, all flags 0.
- MUL 200×3 → `busy` high for 8 cycles; `done` after 8 edges with `output_C`=0x58, `output_hi`=0x02, C=O=1.
- DIV 100/7 → quotient 14, remainder 2. DIV 9/0 → `output_C`=255, `output_hi`=9, O=1.
- `start` asserted mid-MUL is ignored. Then `rst_n` pulsed low mid-MUL → all outputs 0 immediately and no `done` follows.
- SHFT_L 2 by 6 → 128 with C=0. Then SHFT_L 128 by 1 → 0 with Z=1 C=1. CLEAR_FLAGS → flags=0 with `output_C` unchanged.
